// File: rtl/sd_595_rx_pkg.sv
// Shared widths, FSM encodings and frame layout for the 74HC595 serial receiver.
package sd_595_rx_pkg;

  localparam int unsigned FRAME_BITS  = 14;
  localparam int unsigned SEL_W       = 6;
  localparam int unsigned SEG_W       = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned BUF_W       = SEL_W * SEG_W;

  typedef enum logic [3:0] {
    RX_IDLE  = 4'b0001,
    RX_SHIFT = 4'b0010,
    RX_FULL  = 4'b0100,
    RX_OVF   = 4'b1000
  } rx_state_e;

  // First bit shifted lands in the MSB, so the segment field comes first.
  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic [SEL_W-1:0] sel;
  } frame_t;

  function automatic logic is_onehot(input logic [SEL_W-1:0] v);
    return (v != '0) && ((v & (v - SEL_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/sd_595_rx_if.sv
// Pin and status bundle between the display controller side and the receiver.
interface sd_595_rx_if
  import sd_595_rx_pkg::*;
  ;
  logic             ds;
  logic             shcp;
  logic             stcp;
  logic [SEG_W-1:0] seg_o;
  logic [SEL_W-1:0] sel_o;
  logic             frame_vld;
  logic             frame_err;
  logic [BUF_W-1:0] digit_buf;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output ds, shcp, stcp,
    input  seg_o, sel_o, frame_vld, frame_err, digit_buf, bit_cnt
  );

  modport slave (
    input  ds, shcp, stcp,
    output seg_o, sel_o, frame_vld, frame_err, digit_buf, bit_cnt
  );
endinterface

// File: rtl/sd_pin_sync.sv
// Pin synchronizer chain plus history flop; rise is registered level & ~history.
module sd_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/sd_595_rx.sv
// 74HC595-style serial frame receiver with a 6-digit segment buffer.
// Define SD_RX_ONEHOT_CHK_EN to reject frames whose select field is not one-hot.
module sd_595_rx
  import sd_595_rx_pkg::*;
(
  input  logic        sysclk,
  input  logic        rst_n,
  sd_595_rx_if.slave  bus
);

  logic ds_lvl, ds_rise, shcp_lvl, shcp_rise, stcp_lvl, stcp_rise;

  sd_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_ds (
    .sysclk(sysclk), .rst_n(rst_n), .pin_i(bus.ds),   .level(ds_lvl),   .rise(ds_rise));
  sd_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_shcp (
    .sysclk(sysclk), .rst_n(rst_n), .pin_i(bus.shcp), .level(shcp_lvl), .rise(shcp_rise));
  sd_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_stcp (
    .sysclk(sysclk), .rst_n(rst_n), .pin_i(bus.stcp), .level(stcp_lvl), .rise(stcp_rise));

  logic unused_pins_c;
  assign unused_pins_c = ds_rise ^ shcp_lvl ^ stcp_lvl;

  rx_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [BUF_W-1:0]      buf_q, buf_d;
  logic                  vld_q, vld_d;
  logic                  err_q, err_d;
  frame_t                frm_c;
  logic                  sel_ok_c;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
      buf_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      buf_q   <= buf_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // Shift is applied first; a coincident latch then judges the post-shift frame.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    seg_d    = seg_q;
    sel_d    = sel_q;
    buf_d    = buf_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    frm_c    = '0;
    sel_ok_c = 1'b0;

    if (shcp_rise) begin
      sr_d = {sr_q[FRAME_BITS-2:0], ds_lvl};
      if (cnt_q < CNT_W'(FRAME_BITS + 1)) cnt_d = cnt_q + CNT_W'(1);
      unique case (state_q)
        RX_IDLE:  state_d = (cnt_d == CNT_W'(FRAME_BITS)) ? RX_FULL : RX_SHIFT;
        RX_SHIFT: if (cnt_d == CNT_W'(FRAME_BITS)) state_d = RX_FULL;
        RX_FULL:  state_d = RX_OVF;
        RX_OVF:   state_d = RX_OVF;
        default:  state_d = RX_IDLE;
      endcase
    end

    frm_c = frame_t'(sr_d);
`ifdef SD_RX_ONEHOT_CHK_EN
    sel_ok_c = is_onehot(frm_c.sel);
`else
    sel_ok_c = 1'b1;
`endif

    if (stcp_rise) begin
      if ((state_d == RX_FULL) && sel_ok_c) begin
        seg_d = frm_c.seg;
        sel_d = frm_c.sel;
        for (int i = 0; i < int'(SEL_W); i++) begin
          if (frm_c.sel[i]) buf_d[i*SEG_W +: SEG_W] = frm_c.seg;
        end
        vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      state_d = RX_IDLE;
      cnt_d   = '0;
    end
  end

  assign bus.seg_o     = seg_q;
  assign bus.sel_o     = sel_q;
  assign bus.digit_buf = buf_q;
  assign bus.frame_vld = vld_q;
  assign bus.frame_err = err_q;
  assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_sd_595_rx.sv
// Directed bench for sd_595_rx: good, short, overflow, coincident, select and reset scenarios.
module tb_sd_595_rx;
  import sd_595_rx_pkg::*;

  logic sysclk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [BUF_W-1:0] exp_buf;
  logic [SEG_W-1:0] exp_seg;
  logic [SEL_W-1:0] exp_sel;

  sd_595_rx_if bus ();

  sd_595_rx dut (.sysclk(sysclk), .rst_n(rst_n), .bus(bus));

  always #5 sysclk = ~sysclk;

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.ds = v[i];
      cyc(4);
      bus.shcp = 1'b1;
      cyc(4);
      bus.shcp = 1'b0;
      cyc(4);
    end
  endtask

  // Raise stcp and count result pulses over a bounded window.
  task automatic latch(output int nv, output int ne);
    nv = 0;
    ne = 0;
    bus.stcp = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      if (k == 4) bus.stcp = 1'b0;
      if (bus.frame_vld === 1'b1) nv++;
      if (bus.frame_err === 1'b1) ne++;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    checks++;
    if (bus.seg_o !== exp_seg) begin
      errors++;
      $display("FAIL %s seg_o: got %h expected %h", tag, bus.seg_o, exp_seg);
    end
    checks++;
    if (bus.sel_o !== exp_sel) begin
      errors++;
      $display("FAIL %s sel_o: got %h expected %h", tag, bus.sel_o, exp_sel);
    end
    checks++;
    if (bus.digit_buf !== exp_buf) begin
      errors++;
      $display("FAIL %s digit_buf: got %h expected %h", tag, bus.digit_buf, exp_buf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ds = 1'b0;
    bus.shcp = 1'b0;
    bus.stcp = 1'b0;
    exp_buf = '0;
    exp_seg = '0;
    exp_sel = '0;
    cyc(3);
    chk_outputs("reset");
    checks++;
    if (bus.frame_vld !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset pulses: got vld=%b err=%b expected 0/0", bus.frame_vld, bus.frame_err);
    end
    checks++;
    if (bus.bit_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset bit_cnt: got %0d expected 0", bus.bit_cnt);
    end
    rst_n = 1'b1;
    cyc(4);
  endtask

  task automatic test_good_frame();
    int nv, ne;
    send_bits({2'b00, 8'hC0, 6'h20}, 14);
    checks++;
    if (bus.bit_cnt !== 5'd14) begin
      errors++;
      $display("FAIL good bit_cnt before latch: got %0d expected 14", bus.bit_cnt);
    end
    latch(nv, ne);
    checks++;
    if (nv !== 1 || ne !== 0) begin
      errors++;
      $display("FAIL good pulses: got vld=%0d err=%0d expected 1/0", nv, ne);
    end
    exp_seg = 8'hC0;
    exp_sel = 6'h20;
    exp_buf = 48'hC000_0000_0000;
    chk_outputs("good");
    checks++;
    if (bus.bit_cnt !== 5'd0) begin
      errors++;
      $display("FAIL good bit_cnt after latch: got %0d expected 0", bus.bit_cnt);
    end
  endtask

  task automatic test_short_frame();
    int nv, ne;
    send_bits({3'b000, 13'h0C1}, 13);
    checks++;
    if (bus.bit_cnt !== 5'd13) begin
      errors++;
      $display("FAIL short bit_cnt: got %0d expected 13", bus.bit_cnt);
    end
    latch(nv, ne);
    checks++;
    if (nv !== 0 || ne !== 1) begin
      errors++;
      $display("FAIL short pulses: got vld=%0d err=%0d expected 0/1", nv, ne);
    end
    chk_outputs("short");
  endtask

  task automatic test_overflow();
    int nv, ne;
    send_bits(16'h7FFF, 15);
    checks++;
    if (bus.bit_cnt !== 5'd15) begin
      errors++;
      $display("FAIL ovf bit_cnt: got %0d expected 15", bus.bit_cnt);
    end
    send_bits(16'h0001, 1);
    checks++;
    if (bus.bit_cnt !== 5'd15) begin
      errors++;
      $display("FAIL ovf bit_cnt saturate: got %0d expected 15", bus.bit_cnt);
    end
    latch(nv, ne);
    checks++;
    if (nv !== 0 || ne !== 1) begin
      errors++;
      $display("FAIL ovf pulses: got vld=%0d err=%0d expected 0/1", nv, ne);
    end
    chk_outputs("ovf");
    send_bits({2'b00, 8'h66, 6'h04}, 14);
    latch(nv, ne);
    checks++;
    if (nv !== 1 || ne !== 0) begin
      errors++;
      $display("FAIL post-ovf pulses: got vld=%0d err=%0d expected 1/0", nv, ne);
    end
    exp_seg = 8'h66;
    exp_sel = 6'h04;
    exp_buf = 48'hC000_0066_0000;
    chk_outputs("post-ovf");
  endtask

  task automatic test_coincident();
    int nv, ne;
    send_bits({3'b000, 8'h3F, 5'h00}, 13);
    bus.ds = 1'b1;
    cyc(4);
    bus.shcp = 1'b1;
    latch(nv, ne);
    bus.shcp = 1'b0;
    cyc(4);
    checks++;
    if (nv !== 1 || ne !== 0) begin
      errors++;
      $display("FAIL coincident pulses: got vld=%0d err=%0d expected 1/0", nv, ne);
    end
    exp_seg = 8'h3F;
    exp_sel = 6'h01;
    exp_buf = 48'hC000_0066_003F;
    chk_outputs("coincident");
  endtask

  task automatic test_select_check();
    int nv, ne;
    send_bits({2'b00, 8'h5A, 6'h03}, 14);
    latch(nv, ne);
`ifdef SD_RX_ONEHOT_CHK_EN
    checks++;
    if (nv !== 0 || ne !== 1) begin
      errors++;
      $display("FAIL select pulses: got vld=%0d err=%0d expected 0/1", nv, ne);
    end
`else
    checks++;
    if (nv !== 1 || ne !== 0) begin
      errors++;
      $display("FAIL select pulses: got vld=%0d err=%0d expected 1/0", nv, ne);
    end
    exp_seg = 8'h5A;
    exp_sel = 6'h03;
    exp_buf = 48'hC000_0066_5A5A;
`endif
    chk_outputs("select");
  endtask

  task automatic test_reset_mid_frame();
    int nv, ne;
    send_bits(16'h007F, 7);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    nv = 0;
    ne = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      if (bus.frame_vld === 1'b1) nv++;
      if (bus.frame_err === 1'b1) ne++;
    end
    checks++;
    if (nv !== 0 || ne !== 0 || bus.bit_cnt !== 5'd0) begin
      errors++;
      $display("FAIL midreset quiet: got vld=%0d err=%0d cnt=%0d expected 0/0/0", nv, ne, bus.bit_cnt);
    end
    exp_seg = '0;
    exp_sel = '0;
    exp_buf = '0;
    chk_outputs("midreset cleared");
    send_bits({2'b00, 8'h06, 6'h08}, 14);
    latch(nv, ne);
    checks++;
    if (nv !== 1 || ne !== 0) begin
      errors++;
      $display("FAIL midreset pulses: got vld=%0d err=%0d expected 1/0", nv, ne);
    end
    exp_seg = 8'h06;
    exp_sel = 6'h08;
    exp_buf = 48'h0000_0600_0000;
    chk_outputs("midreset frame");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_overflow();
    test_coincident();
    test_select_check();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
